ffs_pipe_param: RTL and testbench

- Parametrised, fully pipelined find-first-set engine. Returns the index of the lowest or highest set bit of a WIDTH-bit vector.
- Next generation of the fixed 1024-bit halving pipeline. Adds:
  - a per-transaction direction mode;
  - an all-zero "found" flag;
  - a sideband tag;
  - ready/valid backpressure on both sides.
- Sits between request producers (allocators, priority arbiters) and consumers that may stall.

---
 rtl/ffs_pkg.sv | 29 ++
 rtl/ffs_halve_stage.sv | 63 ++++++
 rtl/ffs_pipe_param.sv | 102 ++++++++++
 tb/tb_ffs_pipe_param.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffs_pkg.sv
// Shared definitions for the find-first-set pipeline.
//   FFS_LSB_FIRST / FFS_MSB_FIRST : search direction encodings
//   ffs_meta_t                    : per-stage payload at the default tag width
//   ffs_sel_upper()               : halving decision for one stage
package ffs_pkg;

    localparam logic FFS_LSB_FIRST = 1'b0;
    localparam logic FFS_MSB_FIRST = 1'b1;
    localparam int   FFS_TAG_W     = 4;

    typedef struct packed {
        logic                 valid;
        logic                 found;
        logic                 mode;
        logic [FFS_TAG_W-1:0] tag;
    } ffs_meta_t;

    // LSB-first keeps the low half unless it is empty; MSB-first takes the
    // high half whenever it holds anything.
    function automatic logic ffs_sel_upper(input logic mode, input logic lo_any,
                                           input logic hi_any);
        logic sel;
        sel = 1'b0;
        if (mode == FFS_LSB_FIRST) sel = ~lo_any;
        if (mode == FFS_MSB_FIRST) sel = hi_any;
        return sel;
    endfunction

endpackage

// File: rtl/ffs_halve_stage.sv
// One registered halving step of the find-first-set walk.
//   clk, reset      : clock, synchronous active-high reset
//   adv             : pipeline advance enable (shared by all stages)
//   in_data/out_data: W-bit search window in, W/2-bit window out
//   in_index/out_index : partial index, one decision bit appended per stage
//   in_meta/out_meta   : {valid, found, mode, tag} payload
module ffs_halve_stage
    import ffs_pkg::*;
#(
    parameter int W       = 2,
    parameter int IW      = 1,
    parameter int TAG_W   = FFS_TAG_W,
    parameter bit RST_ALL = 1'b0   // clear the whole payload on reset (output stage)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic [W-1:0]     in_data,
    input  logic [IW-1:0]    in_index,
    input  logic [TAG_W+2:0] in_meta,
    output logic [W/2-1:0]   out_data,
    output logic [IW-1:0]    out_index,
    output logic [TAG_W+2:0] out_meta
);

    typedef struct packed {
        logic             valid;
        logic             found;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } meta_t;

    meta_t          m_in;
    meta_t          m_q;
    logic [W/2-1:0] lo;
    logic [W/2-1:0] hi;
    logic           sel_hi;

    assign m_in   = in_meta;
    assign lo     = in_data[W/2-1:0];
    assign hi     = in_data[W-1:W/2];
    assign sel_hi = ffs_sel_upper(m_in.mode, |lo, |hi);

    // The index is carried at full width; earlier stages simply have
    // leading zeros that shift out, which keeps every stage identical.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q.valid <= 1'b0;
            if (RST_ALL) begin
                m_q       <= '0;
                out_data  <= '0;
                out_index <= '0;
            end
        end else if (adv) begin
            m_q       <= m_in;
            out_data  <= sel_hi ? hi : lo;
            out_index <= (in_index << 1) | IW'(sel_hi);
        end
    end

    assign out_meta = m_q;

endmodule

// File: rtl/ffs_pipe_param.sv
// Fully pipelined find-first-set engine with ready/valid on both sides.
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : request handshake
//   in_data, in_msb_first, in_tag : vector, direction (0 = lowest), sideband
//   out_valid/out_ready         : result handshake
//   out_index, out_found        : bit position, nonzero-input flag
//   out_mode, out_tag           : echoes of the request's mode and tag
// Stage 0 registers the request; IDX_W halving stages follow, the last one
// drives the outputs. The whole pipe moves or freezes together.
module ffs_pipe_param
    import ffs_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int TAG_W = FFS_TAG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_msb_first,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_index,
    output logic                     out_found,
    output logic                     out_mode,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic             found;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } meta_t;

    logic             adv;
    logic [WIDTH-1:0] s0_data;
    meta_t            s0_meta;
    logic             final_bit_unused;

    // Bubbles advance too, so a stall only depends on the output register.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_meta.valid <= 1'b0;
        end else if (adv) begin
            s0_meta.valid <= in_valid;
            if (in_valid) begin
                s0_data       <= in_data;
                s0_meta.found <= |in_data;
                s0_meta.mode  <= in_msb_first;
                s0_meta.tag   <= in_tag;
            end
        end
    end

    for (genvar i = 0; i <= IDX_W; i++) begin : g_st
        logic [(WIDTH>>i)-1:0] data;
        logic [IDX_W-1:0]      index;
        meta_t                 meta;

        if (i == 0) begin : g_in
            assign data  = s0_data;
            assign index = '0;
            assign meta  = s0_meta;
        end else begin : g_halve
            ffs_halve_stage #(
                .W       (WIDTH >> (i - 1)),
                .IW      (IDX_W),
                .TAG_W   (TAG_W),
                .RST_ALL (i == IDX_W)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .adv       (adv),
                .in_data   (g_st[i-1].data),
                .in_index  (g_st[i-1].index),
                .in_meta   (g_st[i-1].meta),
                .out_data  (data),
                .out_index (index),
                .out_meta  (meta)
            );
        end
    end

    // The last window is a single bit that merely restates "found".
    assign final_bit_unused = g_st[IDX_W].data[0];

    assign out_valid = g_st[IDX_W].meta.valid;
    assign out_found = g_st[IDX_W].meta.found;
    assign out_mode  = g_st[IDX_W].meta.mode;
    assign out_tag   = g_st[IDX_W].meta.tag;
    // An empty vector walks to an arbitrary leaf; report index 0 instead.
    assign out_index = g_st[IDX_W].meta.found ? g_st[IDX_W].index : '0;

endmodule

// File: tb/tb_ffs_pipe_param.sv
module tb_ffs_pipe_param;
    import ffs_pkg::*;

    localparam int W   = 1024;
    localparam int IW  = 10;
    localparam int TW  = 4;
    localparam int SW  = 8;
    localparam int SIW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_msb_first, out_valid, out_ready, out_found, out_mode;
    logic [W-1:0]  in_data;
    logic [TW-1:0] in_tag, out_tag;
    logic [IW-1:0] out_index;

    logic           s_in_valid, s_in_ready, s_in_msb_first, s_out_valid, s_out_ready, s_out_found, s_out_mode;
    logic [SW-1:0]  s_in_data;
    logic [TW-1:0]  s_in_tag, s_out_tag;
    logic [SIW-1:0] s_out_index;

    ffs_pipe_param #(.WIDTH(W), .TAG_W(TW)) u_big (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_msb_first(in_msb_first), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_found(out_found), .out_mode(out_mode), .out_tag(out_tag));

    ffs_pipe_param #(.WIDTH(SW), .TAG_W(TW)) u_small (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_msb_first(s_in_msb_first), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_index(s_out_index),
        .out_found(s_out_found), .out_mode(s_out_mode), .out_tag(s_out_tag));

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: scan the bits directly; last hit wins for MSB-first.
    function automatic void ref_ffs(input logic [W-1:0] d, input bit msb,
                                    output int idx, output bit found);
        idx = 0; found = 0;
        for (int i = 0; i < W; i++)
            if (d[i]) begin
                if (!found || msb) idx = i;
                found = 1;
            end
    endfunction

    // ---------------- scoreboard on the 1024-bit instance ----------------
    typedef struct { int idx; bit found; bit mode; int tag; int acc; int stl; } exp_t;
    typedef struct { int idx; bit found; int tag; int c; } got_t;
    exp_t exp_q[$];
    got_t log_q[$];
    int   stall_cnt = 0;
    bit   have_prev = 0;
    logic [IW+TW+2:0] prev_out, cur_out;
    exp_t m_e;
    got_t m_g;
    int   m_idx;
    bit   m_found;

    always @(negedge clk) begin
        if (reset) begin
            have_prev = 0;
        end else begin
            if (in_valid && in_ready) begin
                ref_ffs(in_data, in_msb_first, m_idx, m_found);
                m_e.idx = m_idx; m_e.found = m_found; m_e.mode = in_msb_first;
                m_e.tag = int'(in_tag); m_e.acc = cyc + 1; m_e.stl = stall_cnt;
                exp_q.push_back(m_e);
            end
            cur_out = {out_index, out_found, out_mode, out_tag, out_valid};
            if (have_prev) chk("stall_hold", cur_out, prev_out);
            if (out_valid && out_ready) begin
                chk("sb_expect_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    chk("sb_index", out_index, m_e.idx);
                    chk("sb_found", out_found, m_e.found);
                    chk("sb_mode", out_mode, m_e.mode);
                    chk("sb_tag", out_tag, m_e.tag);
                    chk("sb_latency", cyc - m_e.acc, IW + stall_cnt - m_e.stl);
                end
                m_g.idx = int'(out_index); m_g.found = out_found; m_g.tag = int'(out_tag); m_g.c = cyc;
                log_q.push_back(m_g);
            end
            if (out_valid && !out_ready) begin
                have_prev = 1; prev_out = cur_out; stall_cnt++;
            end else begin
                have_prev = 0;
            end
        end
    end

    // ---------------- drivers (called at posedge + #1) ----------------
    task automatic big_send(input logic [W-1:0] d, input bit m, input int t);
        int k;
        in_valid = 1; in_data = d; in_msb_first = m; in_tag = t[TW-1:0];
        k = 0;
        do begin @(negedge clk); k++; end while (!in_ready && k < 200);
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic big_wait(output bit ok);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 300 && log_q.size() < n; k++) @(negedge clk);
        chk("log_count", log_q.size(), n);
    endtask

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        v = '0;
        case ($urandom_range(0, 3))
            0: v = '0;
            1: v[$urandom_range(0, W-1)] = 1'b1;
            2: repeat (3) v[$urandom_range(0, W-1)] = 1'b1;
            default: for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        endcase
        return v;
    endfunction

    typedef struct { logic [W-1:0] d; bit m; int tag; int idx; bit found; } bvec_t;
    typedef struct { logic [SW-1:0] d; bit m; int tag; int idx; bit found; } svec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bvec_t bt[6];
        svec_t st[7];
        logic [W-1:0] d;
        bit ok;
        int acc;
        bit done;

        reset = 1; in_valid = 0; in_data = '0; in_msb_first = 0; in_tag = '0; out_ready = 1;
        s_in_valid = 0; s_in_data = '0; s_in_msb_first = 0; s_in_tag = '0; s_out_ready = 1;

        // --- reset state ---
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_found", out_found, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_s_out_valid", s_out_valid, 0);
        chk("rst_s_out_tag", s_out_tag, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // --- big table: single requests, value and latency ---
        d = '0; d[700] = 1; d[900] = 1;
        bt[0] = '{d, FFS_LSB_FIRST, 3, 700, 1};
        bt[1] = '{d, FFS_MSB_FIRST, 5, 900, 1};
        bt[2] = '{'0, FFS_LSB_FIRST, 9, 0, 0};
        bt[3] = '{'0, FFS_MSB_FIRST, 14, 0, 0};
        d = '0; d[0] = 1;
        bt[4] = '{d, FFS_MSB_FIRST, 1, 0, 1};
        d = '0; d[W-1] = 1;
        bt[5] = '{d, FFS_LSB_FIRST, 15, W-1, 1};
        foreach (bt[i]) begin
            big_send(bt[i].d, bt[i].m, bt[i].tag);
            acc = cyc;
            big_wait(ok);
            chk("tbl_out_valid", ok, 1);
            chk("tbl_latency", cyc - acc, IW);
            chk("tbl_index", out_index, bt[i].idx);
            chk("tbl_found", out_found, bt[i].found);
            chk("tbl_mode", out_mode, bt[i].m);
            chk("tbl_tag", out_tag, bt[i].tag);
            @(posedge clk); #1;
        end

        // --- small instance table ---
        st[0] = '{8'h81, 0, 1, 0, 1};
        st[1] = '{8'h81, 1, 2, 7, 1};
        st[2] = '{8'h80, 0, 3, 7, 1};
        st[3] = '{8'h80, 1, 4, 7, 1};
        st[4] = '{8'hFF, 0, 5, 0, 1};
        st[5] = '{8'hFF, 1, 6, 7, 1};
        st[6] = '{8'h00, 1, 7, 0, 0};
        foreach (st[i]) begin
            s_in_valid = 1; s_in_data = st[i].d; s_in_msb_first = st[i].m; s_in_tag = st[i].tag[TW-1:0];
            @(negedge clk);
            chk("s_in_ready", s_in_ready, 1);
            @(posedge clk); #1;
            s_in_valid = 0;
            acc = cyc;
            ok = 0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                if (s_out_valid) ok = 1;
            end
            chk("s_out_valid", ok, 1);
            chk("s_latency", cyc - acc, SIW);
            chk("s_index", s_out_index, st[i].idx);
            chk("s_found", s_out_found, st[i].found);
            chk("s_tag", s_out_tag, st[i].tag);
            @(posedge clk); #1;
        end

        // --- 12 back-to-back, no backpressure ---
        log_q.delete();
        for (int i = 0; i < 12; i++) begin
            d = '0; d[i*80] = 1;
            big_send(d, FFS_LSB_FIRST, i);
        end
        wait_log(12);
        foreach (log_q[i]) begin
            chk("b2b_index", log_q[i].idx, i*80);
            chk("b2b_tag", log_q[i].tag, i);
            if (i > 0) chk("b2b_no_gap", log_q[i].c, log_q[i-1].c + 1);
        end
        repeat (3) @(posedge clk);
        #1;

        // --- same stream, 5-cycle stall after the 3rd result ---
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d = '0; d[i*80] = 1;
                    big_send(d, FFS_LSB_FIRST, i);
                end
            end
            begin
                for (int k = 0; k < 100 && log_q.size() < 3; k++) begin
                    @(posedge clk); #1;
                end
                out_ready = 0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                end
                @(posedge clk); #1;
                out_ready = 1;
                @(negedge clk);
                chk("unstall_in_ready", in_ready, 1);
                @(posedge clk); #1;
            end
        join
        wait_log(12);
        repeat (15) @(negedge clk);
        chk("stall_no_dup", log_q.size(), 12);
        foreach (log_q[i]) begin
            chk("stall_index", log_q[i].idx, i*80);
            chk("stall_tag", log_q[i].tag, i);
        end
        @(posedge clk); #1;

        // --- reset with 6 requests in flight ---
        log_q.delete();
        for (int i = 0; i < 6; i++) begin
            d = '0; d[i*100 + 7] = 1;
            big_send(d, FFS_MSB_FIRST, i + 8);
        end
        reset = 1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("flush_out_valid", out_valid, 0);
        end
        chk("flush_no_stale", log_q.size(), 0);
        @(posedge clk); #1;
        d = '0; d[333] = 1; d[44] = 1;
        big_send(d, FFS_MSB_FIRST, 6);
        acc = cyc;
        big_wait(ok);
        chk("post_flush_valid", ok, 1);
        chk("post_flush_latency", cyc - acc, IW);
        chk("post_flush_index", out_index, 333);
        chk("post_flush_tag", out_tag, 6);
        @(posedge clk); #1;

        // --- randomized traffic with random backpressure ---
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk); #1;
                    end
                    big_send(rnd_vec(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        chk("rand_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
